// File: rtl/lm32_irq_source.sv
// Interrupt source block: sticky pending bits, mask, software force, and a
// per-line deassert holdoff. Define CFG_IRQ_SOURCE_EDGE_EN for synchronized rising-edge events.
module lm32_irq_source #(
  parameter int INTERRUPTS = 8,
  parameter int HOLDOFF    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INTERRUPTS-1:0] event_i,
  input  logic [1:0]            reg_addr_i,
  input  logic                  reg_we_i,
  input  logic                  reg_stb_i,
  input  logic [31:0]           reg_wdata_i,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_ack_o,
  output logic [INTERRUPTS-1:0] interrupt_n
);

  localparam logic [3:0] HOLDOFF_L = 4'(HOLDOFF);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                  state_q, state_d;
  logic                    accept;
  logic                    wr;
  logic [INTERRUPTS-1:0]   wmask;
  logic [INTERRUPTS-1:0]   w1c;
  logic [INTERRUPTS-1:0]   w1s;
  logic [INTERRUPTS-1:0]   qual;
  logic [INTERRUPTS-1:0]   rearm;
  logic [INTERRUPTS-1:0]   hold;
  logic [INTERRUPTS-1:0]   pend_q, pend_d;
  logic [INTERRUPTS-1:0]   mask_q, mask_d;
  logic [INTERRUPTS-1:0]   irq_n_q, irq_n_d;
  logic [INTERRUPTS-1:0]   rd_sel;
  logic [31:0]             rd_ext;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ack_q;
  logic                    wdata_unused;

  assign wdata_unused = ^reg_wdata_i;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reg_stb_i) begin
          accept  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CFG_IRQ_SOURCE_EDGE_EN
  logic [INTERRUPTS-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= event_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign qual = sync2_q & ~prev_q;
`else
  assign qual = event_i;
`endif

  always_comb begin
    wr     = accept & reg_we_i;
    wmask  = reg_wdata_i[INTERRUPTS-1:0];
    w1c    = (wr && reg_addr_i == 2'd0) ? wmask : '0;
    w1s    = (wr && reg_addr_i == 2'd2) ? wmask : '0;
    mask_d = (wr && reg_addr_i == 2'd1) ? wmask : mask_q;
    // A concurrent event wins over the clear, so the bit can never be lost.
    pend_d = (pend_q & ~w1c) | w1s | qual;
    // Any clear of a set bit restarts holdoff, even when a new event keeps it
    // pending; the CPU then sees a fresh deassert/assert on the pin.
    rearm  = pend_q & w1c;
    irq_n_d = ~(pend_q & mask_q & ~hold);
  end

  always_comb begin
    rd_sel = '0;
    case (reg_addr_i)
      2'd0:    rd_sel = pend_q;
      2'd1:    rd_sel = mask_q;
      2'd2:    rd_sel = '0;
      2'd3:    rd_sel = pend_q & mask_q;
      default: rd_sel = '0;
    endcase
    rd_ext = '0;
    rd_ext[INTERRUPTS-1:0] = rd_sel;
    rdata_d = accept ? rd_ext : '0;
  end

  for (genvar gi = 0; gi < INTERRUPTS; gi++) begin : g_hold
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q <= '0;
      end else if (rearm[gi]) begin
        cnt_q <= HOLDOFF_L;
      end else if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end

    assign hold[gi] = (cnt_q != 4'd0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      mask_q  <= '0;
      irq_n_q <= '1;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      irq_n_q <= irq_n_d;
      rdata_q <= rdata_d;
      ack_q   <= accept;
    end
  end

  assign reg_rdata_o = rdata_q;
  assign reg_ack_o   = ack_q;
  assign interrupt_n = irq_n_q;

endmodule

// File: tb/tb_lm32_irq_source.sv
// Directed bench for lm32_irq_source: register reads go through a scoreboard
// queue checked by a monitor on ack; pins and ack timing are checked inline.
module tb_lm32_irq_source;

`ifdef CFG_IRQ_SOURCE_EDGE_EN
  localparam int EVT_LAT = 3;
`else
  localparam int EVT_LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  event_i;
  logic [1:0]  reg_addr_i;
  logic        reg_we_i;
  logic        reg_stb_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_ack_o;
  logic [7:0]  interrupt_n;

  int total  = 0;
  int bad    = 0;
  int pushes = 0;
  int acks   = 0;
  logic [31:0] exp_q[$];

  lm32_irq_source #(.INTERRUPTS(8), .HOLDOFF(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .event_i     (event_i),
    .reg_addr_i  (reg_addr_i),
    .reg_we_i    (reg_we_i),
    .reg_stb_i   (reg_stb_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_ack_o   (reg_ack_o),
    .interrupt_n (interrupt_n)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every ack pops one expected read value.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      if (reg_ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'd1, 32'd0);
        end else begin
          acks++;
          chk("rdata", reg_rdata_o, exp_q.pop_front());
        end
      end else begin
        chk("rdata_idle_zero", reg_rdata_o, 32'd0);
      end
    end
  end

  task automatic access(input logic [1:0] a, input logic we, input logic [31:0] wd,
                        input logic [31:0] exp, input logic [7:0] pin1, input logic [7:0] pin2);
    reg_addr_i  = a;
    reg_we_i    = we;
    reg_wdata_i = wd;
    reg_stb_i   = 1'b1;
    exp_q.push_back(exp);
    pushes++;
    tick();
    chk("ack_high", {31'd0, reg_ack_o}, 32'd1);
    chk("pin_accept", {24'd0, interrupt_n}, {24'd0, pin1});
    reg_stb_i = 1'b0;
    reg_we_i  = 1'b0;
    tick();
    chk("ack_low", {31'd0, reg_ack_o}, 32'd0);
    chk("pin_after", {24'd0, interrupt_n}, {24'd0, pin2});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; event_i = '0; reg_addr_i = '0; reg_we_i = 1'b0;
    reg_stb_i = 1'b0; reg_wdata_i = '0;
    #23;
    chk("rst_pins", {24'd0, interrupt_n}, 32'h0000_00FF);
    chk("rst_ack", {31'd0, reg_ack_o}, 32'd0);
    chk("rst_rdata", reg_rdata_o, 32'd0);
    tick();
    rst_i = 1'b1;
    tick();

    // Mask line 0, pulse its event, watch PEND and pin latency.
    access(2'd1, 1'b1, 32'h01, 32'h00, 8'hFF, 8'hFF);
    event_i[0] = 1'b1;
    for (int c = 1; c <= EVT_LAT + 1; c++) begin
      tick();
      if (c == 1) event_i[0] = 1'b0;
      chk("evt0_pin", {24'd0, interrupt_n}, (c <= EVT_LAT) ? 32'hFF : 32'hFE);
    end
    access(2'd0, 1'b0, 32'h0, 32'h01, 8'hFE, 8'hFE);
    access(2'd3, 1'b0, 32'h0, 32'h01, 8'hFE, 8'hFE);

    // W1C line 0: pin releases one cycle after the clear.
    access(2'd0, 1'b1, 32'h01, 32'h01, 8'hFE, 8'hFF);
    access(2'd0, 1'b0, 32'h0, 32'h00, 8'hFF, 8'hFF);

    // Event on bit 3 coinciding with its W1C: set wins, pin pulses high for holdoff.
    access(2'd1, 1'b1, 32'h08, 32'h01, 8'hFF, 8'hFF);
    access(2'd2, 1'b1, 32'h08, 32'h00, 8'hFF, 8'hF7);
    event_i[3] = 1'b1;
    repeat (EVT_LAT - 1) tick();
    reg_addr_i = 2'd0; reg_we_i = 1'b1; reg_wdata_i = 32'h08; reg_stb_i = 1'b1;
    exp_q.push_back(32'h08);
    pushes++;
    tick();
    chk("coin_ack", {31'd0, reg_ack_o}, 32'd1);
    chk("coin_pin0", {24'd0, interrupt_n}, 32'hF7);
    reg_stb_i = 1'b0; reg_we_i = 1'b0; event_i[3] = 1'b0;
    tick();
    chk("coin_pin1", {24'd0, interrupt_n}, 32'hFF);
    tick();
    chk("coin_pin2", {24'd0, interrupt_n}, 32'hFF);
    tick();
    chk("coin_pin3", {24'd0, interrupt_n}, 32'hF7);
    access(2'd0, 1'b0, 32'h0, 32'h08, 8'hF7, 8'hF7);

    // Masked FORCE, then unmask with upper write bits ignored.
    access(2'd1, 1'b1, 32'h00, 32'h08, 8'hF7, 8'hFF);
    access(2'd0, 1'b1, 32'h08, 32'h08, 8'hFF, 8'hFF);
    access(2'd2, 1'b1, 32'h80, 32'h00, 8'hFF, 8'hFF);
    access(2'd3, 1'b0, 32'h0, 32'h00, 8'hFF, 8'hFF);
    access(2'd0, 1'b0, 32'h0, 32'h80, 8'hFF, 8'hFF);
    access(2'd1, 1'b1, 32'hABCD_0080, 32'h00, 8'hFF, 8'h7F);
    access(2'd1, 1'b0, 32'h0, 32'h80, 8'h7F, 8'h7F);

    // Strobe held for four cycles: exactly two accesses.
    reg_addr_i = 2'd3; reg_we_i = 1'b0; reg_stb_i = 1'b1;
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h80);
    pushes += 2;
    chk("hold_ack0", {31'd0, reg_ack_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_ack", {31'd0, reg_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    reg_stb_i = 1'b0;
    tick();

    // All lines pending and enabled, then reset in the middle of an ack.
    access(2'd2, 1'b1, 32'hFF, 32'h00, 8'h7F, 8'h7F);
    access(2'd1, 1'b1, 32'hFF, 32'h80, 8'h7F, 8'h00);
    reg_addr_i = 2'd0; reg_we_i = 1'b0; reg_stb_i = 1'b1;
    tick();
    chk("midack_ack", {31'd0, reg_ack_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_pins", {24'd0, interrupt_n}, 32'hFF);
    chk("async_rst_ack", {31'd0, reg_ack_o}, 32'd0);
    chk("async_rst_rdata", reg_rdata_o, 32'd0);
    reg_stb_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    access(2'd0, 1'b0, 32'h0, 32'h00, 8'hFF, 8'hFF);
    access(2'd1, 1'b0, 32'h0, 32'h00, 8'hFF, 8'hFF);
    access(2'd3, 1'b0, 32'h0, 32'h00, 8'hFF, 8'hFF);

    tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("ack_count", acks, pushes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
